// File: rtl/exe_pkg.sv
// Shared constants and types for the EXE pipeline stage.
// Optional flag output is enabled by defining EXE_ALU_FLAGS_EN.
package exe_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_W     = 3;
  localparam int MEMSIG_W  = 8;
  localparam int CTRL_W    = 3;
  localparam int FLAGS_W   = 4;

  // Bit positions inside the EXE control bundle
  localparam int ALUSRC    = 0;
  localparam int ALUOP_LSB = 1;

  typedef enum logic [1:0] {
    OP_AND   = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_PASSB = 2'b11
  } alu_op_e;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 16-bit ALU: AND / ADD / SUB / pass-B, modulo 2^16.
// Defining EXE_ALU_FLAGS_EN adds the {N, Z, C, V} flag output.
module alu
  import exe_pkg::*;
(
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  input  alu_op_e            op_i,
  output logic [DATA_W-1:0]  result_o
`ifdef EXE_ALU_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0] flags_o
`endif
);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      OP_AND:   result_o = a_i & b_i;
      OP_ADD:   result_o = a_i + b_i;
      OP_SUB:   result_o = a_i - b_i;
      OP_PASSB: result_o = b_i;
      default:  result_o = '0;
    endcase
  end

`ifdef EXE_ALU_FLAGS_EN
  logic flag_n, flag_z, flag_c, flag_v;

  // Carry of an add shows up as a wrapped sum smaller than an operand;
  // borrow of a subtract is simply an unsigned A < B.
  always_comb begin
    flag_n = result_o[DATA_W-1];
    flag_z = (result_o == '0);
    flag_c = 1'b0;
    flag_v = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        flag_c = (result_o < a_i);
        flag_v = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                 (result_o[DATA_W-1] != a_i[DATA_W-1]);
      end
      OP_SUB: begin
        flag_c = (a_i < b_i);
        flag_v = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                 (result_o[DATA_W-1] != a_i[DATA_W-1]);
      end
      default: begin
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
    endcase
  end

  assign flags_o = {flag_n, flag_z, flag_c, flag_v};
`endif

endmodule

// File: rtl/exe_stage.sv
// EXE pipeline stage: operand-B mux, ALU, and the EXE/MEM register.
// Defining EXE_ALU_FLAGS_EN exposes the combinational alu_flags output.
module exe_stage
  import exe_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   valueA_EXE,
  input  logic [DATA_W-1:0]   valueB_EXE,
  input  logic [DATA_W-1:0]   immediate_EXE,
  input  logic [CTRL_W-1:0]   signals,
  input  logic [DATA_W-1:0]   PC_EXE,
  input  logic [REG_W-1:0]    Rd_EXE,
  input  logic [MEMSIG_W-1:0] MEM_signals_IN,
  output logic [DATA_W-1:0]   AluResult_EXE,
  output logic [DATA_W-1:0]   AluResult_MEM,
  output logic [DATA_W-1:0]   valueB_MEM,
  output logic [DATA_W-1:0]   immediate_MEM,
  output logic [DATA_W-1:0]   PC_MEM,
  output logic [REG_W-1:0]    Rd_MEM,
  output logic [MEMSIG_W-1:0] MEM_signals
`ifdef EXE_ALU_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0]  alu_flags
`endif
);

  logic [DATA_W-1:0] operand_b;
  alu_op_e           alu_op;

  assign operand_b = signals[ALUSRC] ? immediate_EXE : valueB_EXE;
  assign alu_op    = alu_op_e'(signals[ALUOP_LSB +: 2]);

  alu u_alu (
    .a_i      (valueA_EXE),
    .b_i      (operand_b),
    .op_i     (alu_op),
    .result_o (AluResult_EXE)
`ifdef EXE_ALU_FLAGS_EN
    ,
    .flags_o  (alu_flags)
`endif
  );

  // EXE/MEM register: loads every cycle; store data is the raw register B
  logic [DATA_W-1:0]   alu_res_d, alu_res_q;
  logic [DATA_W-1:0]   value_b_d, value_b_q;
  logic [DATA_W-1:0]   imm_d,     imm_q;
  logic [DATA_W-1:0]   pc_d,      pc_q;
  logic [REG_W-1:0]    rd_d,      rd_q;
  logic [MEMSIG_W-1:0] mem_sig_d, mem_sig_q;

  always_comb begin
    alu_res_d = AluResult_EXE;
    value_b_d = valueB_EXE;
    imm_d     = immediate_EXE;
    pc_d      = PC_EXE;
    rd_d      = Rd_EXE;
    mem_sig_d = MEM_signals_IN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_res_q <= '0;
      value_b_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      mem_sig_q <= '0;
    end else begin
      alu_res_q <= alu_res_d;
      value_b_q <= value_b_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      mem_sig_q <= mem_sig_d;
    end
  end

  assign AluResult_MEM = alu_res_q;
  assign valueB_MEM    = value_b_q;
  assign immediate_MEM = imm_q;
  assign PC_MEM        = pc_q;
  assign Rd_MEM        = rd_q;
  assign MEM_signals   = mem_sig_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage; also checks alu_flags when EXE_ALU_FLAGS_EN is defined.
module tb_exe_stage;

  logic        clk;
  logic        reset;
  logic [15:0] valueA_EXE, valueB_EXE, immediate_EXE, PC_EXE;
  logic [2:0]  signals, Rd_EXE;
  logic [7:0]  MEM_signals_IN;
  logic [15:0] AluResult_EXE, AluResult_MEM, valueB_MEM, immediate_MEM, PC_MEM;
  logic [2:0]  Rd_MEM;
  logic [7:0]  MEM_signals;
`ifdef EXE_ALU_FLAGS_EN
  logic [3:0]  alu_flags;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] alu, vb, imm, pc;
    logic [2:0]  rd;
    logic [7:0]  ms;
  } exp_t;

  exp_t sb_q[$];

  exe_stage dut (
    .clk            (clk),
    .reset          (reset),
    .valueA_EXE     (valueA_EXE),
    .valueB_EXE     (valueB_EXE),
    .immediate_EXE  (immediate_EXE),
    .signals        (signals),
    .PC_EXE         (PC_EXE),
    .Rd_EXE         (Rd_EXE),
    .MEM_signals_IN (MEM_signals_IN),
    .AluResult_EXE  (AluResult_EXE),
    .AluResult_MEM  (AluResult_MEM),
    .valueB_MEM     (valueB_MEM),
    .immediate_MEM  (immediate_MEM),
    .PC_MEM         (PC_MEM),
    .Rd_MEM         (Rd_MEM),
    .MEM_signals    (MEM_signals)
`ifdef EXE_ALU_FLAGS_EN
    ,
    .alu_flags      (alu_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return b;
    endcase
  endfunction

`ifdef EXE_ALU_FLAGS_EN
  function automatic logic [3:0] model_flags(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] op);
    logic [15:0] r;
    logic        n, z, c, v;
    r = model_alu(a, b, op);
    n = r[15];
    z = (r == 16'h0000);
    c = 1'b0;
    v = 1'b0;
    if (op == 2'b01) begin
      c = ({1'b0, a} + {1'b0, b}) > 17'h0FFFF;
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end else if (op == 2'b10) begin
      c = a < b;
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end
    return {n, z, c, v};
  endfunction
`endif

  // Apply one cycle of stimulus, check the combinational result, then
  // after the edge pop the scoreboard and check the registered outputs.
  task automatic step(input logic rst, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] imm, input logic [15:0] pc, input logic [2:0] rd,
                      input logic [7:0] ms, input logic [2:0] sig);
    logic [15:0] bop;
    exp_t        e;
    reset          = rst;
    valueA_EXE     = a;
    valueB_EXE     = b;
    immediate_EXE  = imm;
    PC_EXE         = pc;
    Rd_EXE         = rd;
    MEM_signals_IN = ms;
    signals        = sig;
    #1;
    bop = sig[0] ? imm : b;
    chk("alu_exe", {16'h0, AluResult_EXE}, {16'h0, model_alu(a, bop, sig[2:1])});
`ifdef EXE_ALU_FLAGS_EN
    chk("alu_flags", {28'h0, alu_flags}, {28'h0, model_flags(a, bop, sig[2:1])});
`endif
    if (rst) begin
      e.alu = '0; e.vb = '0; e.imm = '0; e.pc = '0; e.rd = '0; e.ms = '0;
    end else begin
      e.alu = model_alu(a, bop, sig[2:1]);
      e.vb = b; e.imm = imm; e.pc = pc; e.rd = rd; e.ms = ms;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("alu_mem", {16'h0, AluResult_MEM}, {16'h0, e.alu});
    chk("vb_mem",  {16'h0, valueB_MEM},    {16'h0, e.vb});
    chk("imm_mem", {16'h0, immediate_MEM}, {16'h0, e.imm});
    chk("pc_mem",  {16'h0, PC_MEM},        {16'h0, e.pc});
    chk("rd_mem",  {29'h0, Rd_MEM},        {29'h0, e.rd});
    chk("ms_mem",  {24'h0, MEM_signals},   {24'h0, e.ms});
  endtask

  initial begin
    reset = 1'b1;
    valueA_EXE = '0; valueB_EXE = '0; immediate_EXE = '0; PC_EXE = '0;
    Rd_EXE = '0; MEM_signals_IN = '0; signals = '0;
    @(posedge clk);
    #1;

    // Reset with nonzero inputs: registers must read zero
    step(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 3'd6, 8'hFF, 3'b010);

    // ADD register path
    step(1'b0, 16'h0005, 16'h0003, 16'h0000, 16'h0100, 3'd1, 8'h01, 3'b010);
    chk("add_lit", {16'h0, AluResult_EXE}, 32'h0000_0008);

    // Immediate SUB wrapping below zero
    step(1'b0, 16'h0000, 16'h0055, 16'h0001, 16'h0102, 3'd2, 8'h03, 3'b101);
    chk("sub_wrap_lit", {16'h0, AluResult_EXE}, 32'h0000_FFFF);
`ifdef EXE_ALU_FLAGS_EN
    chk("sub_wrap_flags", {28'h0, alu_flags}, 32'h0000_000A);
`endif

    // AND, PASSB register, PASSB immediate
    step(1'b0, 16'hF0F0, 16'h3C3C, 16'h0007, 16'h0104, 3'd3, 8'h00, 3'b000);
    chk("and_lit", {16'h0, AluResult_EXE}, 32'h0000_3030);
    step(1'b0, 16'hF0F0, 16'h3C3C, 16'h0007, 16'h0106, 3'd3, 8'h00, 3'b110);
    chk("passb_lit", {16'h0, AluResult_EXE}, 32'h0000_3C3C);
    step(1'b0, 16'hF0F0, 16'h3C3C, 16'h0007, 16'h0108, 3'd3, 8'h00, 3'b111);
    chk("passimm_lit", {16'h0, AluResult_EXE}, 32'h0000_0007);

    // Pass-through fields with immediate operand; store data stays valueB
    step(1'b0, 16'h0001, 16'h1234, 16'h0020, 16'h0012, 3'd5, 8'hA5, 3'b011);
    chk("pass_vb_lit", {16'h0, valueB_MEM}, 32'h0000_1234);
    chk("pass_pc_lit", {16'h0, PC_MEM}, 32'h0000_0012);

    // Add wrap and signed overflow
    step(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h010A, 3'd4, 8'h11, 3'b010);
    chk("add_wrap_lit", {16'h0, AluResult_EXE}, 32'h0000_0000);
    step(1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h010C, 3'd4, 8'h11, 3'b010);
    chk("ovf_lit", {16'h0, AluResult_EXE}, 32'h0000_8000);
`ifdef EXE_ALU_FLAGS_EN
    chk("ovf_flags", {28'h0, alu_flags}, 32'h0000_0009);
`endif

    // Reset priority over a load, then resume
    step(1'b0, 16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 3'd7, 8'h5A, 3'b010);
    step(1'b1, 16'h1000, 16'h0234, 16'h0056, 16'h0078, 3'd2, 8'hC3, 3'b010);
    chk("rst_alu_live", {16'h0, AluResult_EXE}, 32'h0000_1234);
    step(1'b0, 16'h1000, 16'h0234, 16'h0056, 16'h0078, 3'd2, 8'hC3, 3'b010);
    chk("resume_lit", {16'h0, AluResult_MEM}, 32'h0000_1234);

    // Random traffic with occasional reset and bubbles
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 9) == 0),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           3'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
           3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
